// File: rtl/ysyx_25040105_mem_pkg.sv
// Shared types and constants for the memory responder.
package ysyx_25040105_mem_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned MaskW = 4;
  localparam logic [31:0] DefaultBaseAddr = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_25040105_mem_array.sv
// Single-port word array with byte-lane write mask and registered read data.
module ysyx_25040105_mem_array
  import ysyx_25040105_mem_pkg::*;
#(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             wen,
  input  logic [AddrW-1:0] addr,
  input  logic [WordW-1:0] wdata,
  input  logic [MaskW-1:0] wmask,
  output logic [WordW-1:0] rdata
);

  logic [WordW-1:0] mem [Depth];

  // A write leaves rdata untouched; the responder masks it to zero for writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (wen) begin
        for (int i = 0; i < int'(MaskW); i++) begin
          if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ysyx_25040105_mem_responder.sv
// Valid/ready memory responder with programmable latency.
module ysyx_25040105_mem_responder
  import ysyx_25040105_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DefaultBaseAddr,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wen,
  input  logic [31:0]      req_addr,
  input  logic [WordW-1:0] req_wdata,
  input  logic [MaskW-1:0] req_wmask,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WordW-1:0] resp_rdata,
  output logic             resp_err
);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             wen_q;
  logic [31:0]      addr_q;
  logic [WordW-1:0] wdata_q;
  logic [MaskW-1:0] wmask_q;
  logic             valid_q;
  logic             err_q;

  logic             acc_wen;
  logic [31:0]      acc_addr;
  logic [WordW-1:0] acc_wdata;
  logic [MaskW-1:0] acc_wmask;
  logic             enter_resp;
  logic             in_range;

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = valid_q;
  assign resp_err   = err_q;

  // With zero latency the access happens on the accept edge, so use the live request.
  always_comb begin
    acc_wen   = wen_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wmask = wmask_q;
    if (state_q == StIdle) begin
      acc_wen   = req_wen;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end
  end

  assign enter_resp = ((state_q == StIdle) && req_valid && (LATENCY == 0)) ||
                      ((state_q == StWait) && (cnt_q == 4'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            wen_q   <= req_wen;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            cnt_q   <= 4'(LATENCY);
            if (LATENCY == 0) begin
              state_q <= StResp;
              valid_q <= 1'b1;
              err_q   <= !in_range;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StResp;
            valid_q <= 1'b1;
            err_q   <= !in_range;
          end
        end
        StResp: begin
          if (resp_ready) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);

  logic [32:0]      addr_ext;
  logic [32:0]      lo_ext;
  logic [32:0]      hi_ext;
  logic [31:0]      offset;
  logic [AddrW-1:0] idx;
  logic [WordW-1:0] arr_rdata;
  logic             zero_q;

  // 33-bit compare so BASE_ADDR + size cannot wrap.
  assign addr_ext = {1'b0, acc_addr};
  assign lo_ext   = {1'b0, BASE_ADDR};
  assign hi_ext   = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS * 4);
  assign in_range = (addr_ext >= lo_ext) && (addr_ext < hi_ext);
  assign offset   = acc_addr - BASE_ADDR;
  assign idx      = AddrW'(offset >> 2);

  // Array output register holds the read word; zero_q blanks it for writes and errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b1;
    end else if (enter_resp) begin
      zero_q <= acc_wen || !in_range;
    end
  end

  assign resp_rdata = zero_q ? '0 : arr_rdata;

  ysyx_25040105_mem_array #(
    .Depth(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .en   (enter_resp && in_range && !rst),
    .wen  (acc_wen),
    .addr (idx),
    .wdata(acc_wdata),
    .wmask(acc_wmask),
    .rdata(arr_rdata)
  );

endmodule
